pixel_frame_reader: RTL and testbench

- Receiving end of the pixel-write interface (x, y, color) driven by the drawing blocks (clear, line, fill).
- Captures writes that fall inside a fixed rectangular region into an internal 1-bit-per-pixel bitmap and keeps a running count of lit pixels.
- On request, reads the region back out in the same scan order the drawing blocks use, through a valid/ready handshake. Used for on-screen readback and for self-check of drawing blocks.

---
 rtl/pixel_frame_reader.sv | 108 ++++++++++
 tb/tb_pixel_frame_reader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_reader.sv
// Pixel-write sink: latches in-region writes into a 1bpp bitmap, tracks lit pixels,
// and streams the region back out (y inner, x outer) over a valid/ready handshake.
module pixel_frame_reader #(
  parameter int unsigned REG_W = 7,
  parameter int unsigned REG_H = 5,
  parameter int unsigned X_W   = 10,
  parameter int unsigned Y_W   = 9,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [X_W-1:0]   wr_x,
  input  logic [Y_W-1:0]   wr_y,
  input  logic             wr_color,
  input  logic             start,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [X_W-1:0]   rd_x,
  output logic [Y_W-1:0]   rd_y,
  output logic             rd_color,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] lit_count
);

  localparam int unsigned NPIX  = REG_W * REG_H;
  localparam int unsigned IDX_W = $clog2(NPIX);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  state_t            state;
  logic [NPIX-1:0]   bitmap;
  logic              wr_hit;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              last_pix;

  // Index is only meaningful when the coordinate is inside the region.
  assign wr_hit   = wr_en && (wr_x < X_W'(REG_W)) && (wr_y < Y_W'(REG_H));
  assign wr_idx   = IDX_W'(wr_x) * IDX_W'(REG_H) + IDX_W'(wr_y);
  assign rd_idx   = IDX_W'(rd_x) * IDX_W'(REG_H) + IDX_W'(rd_y);
  assign rd_color = bitmap[rd_idx];
  assign last_pix = (rd_x == X_W'(REG_W - 1)) && (rd_y == Y_W'(REG_H - 1));

  // Bitmap and lit counter move together; only real bit flips touch the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitmap    <= '0;
      lit_count <= '0;
    end else if (wr_hit && (bitmap[wr_idx] != wr_color)) begin
      bitmap[wr_idx] <= wr_color;
      lit_count      <= wr_color ? lit_count + CNT_W'(1) : lit_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_x     <= '0;
      rd_y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= SCAN;
            rd_valid <= 1'b1;
            busy     <= 1'b1;
            rd_x     <= '0;
            rd_y     <= '0;
          end
        end
        SCAN: begin
          if (rd_ready) begin
            if (last_pix) begin
              state    <= FIN;
              rd_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else if (rd_y < Y_W'(REG_H - 1)) begin
              rd_y <= rd_y + Y_W'(1);
            end else begin
              rd_y <= '0;
              rd_x <= rd_x + X_W'(1);
            end
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          rd_x  <= '0;
          rd_y  <= '0;
        end
        default: begin
          state    <= IDLE;
          rd_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_frame_reader.sv
// Scoreboard bench for pixel_frame_reader: stimulus queues expected beats, a
// negedge monitor pops and compares every accepted beat.
module tb_pixel_frame_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic       wr_color;
  logic       start;
  logic       rd_ready;
  logic       rd_valid;
  logic [9:0] rd_x;
  logic [8:0] rd_y;
  logic       rd_color;
  logic       busy;
  logic       done;
  logic [5:0] lit_count;

  pixel_frame_reader dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_color(wr_color), .start(start), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_x(rd_x), .rd_y(rd_y), .rd_color(rd_color), .busy(busy), .done(done),
    .lit_count(lit_count)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int c;} beat_t;
  beat_t       q[$];
  int          tests = 0;
  int          fails = 0;
  int          done_pulses = 0;
  logic [34:0] model;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected beats in scan order, colors from the hand-set model bitmap.
  task automatic push_scan();
    for (int x = 0; x < 7; x++)
      for (int y = 0; y < 5; y++)
        q.push_back('{x, y, int'(model[x*5+y])});
  endtask

  // Monitor: compare accepted beats, check coordinate hold while stalled.
  int  hx, hy;
  bit  hold_pend = 0;
  always @(negedge clk) begin
    if (!reset) begin
      hold_pend = 0;
    end else begin
      if (hold_pend && rd_valid) begin
        check("hold_x", int'(rd_x), hx);
        check("hold_y", int'(rd_y), hy);
      end
      if (rd_valid && rd_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL extra_beat: got (%0d,%0d) expected no beat", rd_x, rd_y);
        end else begin
          beat_t e;
          e = q.pop_front();
          if (int'(rd_x) != e.x || int'(rd_y) != e.y || int'(rd_color) != e.c) begin
            fails++;
            $display("FAIL beat: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                     rd_x, rd_y, rd_color, e.x, e.y, e.c);
          end
        end
      end
      if (done) begin
        done_pulses++;
        check("done_after_last_beat_pending", q.size(), 0);
      end
      hold_pend = rd_valid && !rd_ready;
      hx = int'(rd_x);
      hy = int'(rd_y);
    end
  end

  // All tasks below start and end at posedge+1.
  task automatic do_write(input int x, input int y, input logic c);
    wr_en = 1'b1; wr_x = 10'(x); wr_y = 9'(y); wr_color = c;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_lit_count", int'(lit_count), 0);
    check("rst_rd_x", int'(rd_x), 0);
    q.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: pattern plus stall/write at (3,1)
  task automatic run_scan(input int mode);
    int  n = 0;
    int  k = 0;
    bit  stalled = 0;
    push_scan();
    rd_ready = 1'b1;
    pulse_start();
    while (!done && n < 300) begin
      if (mode == 2 && !stalled && rd_valid && rd_x == 10'd3 && rd_y == 9'd1) begin
        stalled = 1;
        check("stall_color_before", int'(rd_color), 0);
        check("stall_lit_before", int'(lit_count), 0);
        rd_ready = 1'b0;
        wr_en = 1'b1; wr_x = 10'd3; wr_y = 9'd1; wr_color = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        check("stall_x", int'(rd_x), 3);
        check("stall_y", int'(rd_y), 1);
        check("stall_color_after", int'(rd_color), 1);
        check("stall_lit_after", int'(lit_count), 1);
        check("stall_busy", int'(busy), 1);
      end
      rd_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      k++;
      @(posedge clk); #1;
      n++;
    end
    check("scan_done_seen", int'(done), 1);
    if (mode == 0) check("done_latency", n, 35);
    if (mode == 2) check("stall_reached", int'(stalled), 1);
    check("all_beats_presented", q.size(), 0);
    @(posedge clk); #1;
    check("done_one_cycle", int'(done), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_rd_valid", int'(rd_valid), 0);
    check("idle_rd_x", int'(rd_x), 0);
    check("idle_rd_y", int'(rd_y), 0);
  endtask

  initial begin
    int dp;
    int n;
    reset = 1'b0; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_color = 1'b0;
    start = 1'b0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_valid", int'(rd_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_rd_x", int'(rd_x), 0);
    check("reset_rd_y", int'(rd_y), 0);
    check("reset_lit", int'(lit_count), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Empty bitmap scan
    model = '0;
    run_scan(0);
    check("lit_empty", int'(lit_count), 0);

    // Lit pixels at beats 13 and 34; duplicate write must not double-count
    do_write(2, 3, 1'b1);
    do_write(6, 4, 1'b1);
    do_write(2, 3, 1'b1);
    check("lit_two", int'(lit_count), 2);
    model = '0; model[13] = 1'b1; model[34] = 1'b1;
    run_scan(0);
    do_write(6, 4, 1'b0);
    check("lit_clear_one", int'(lit_count), 1);

    // Out-of-region writes after a fresh reset
    async_reset();
    do_write(7, 0, 1'b1);
    do_write(0, 5, 1'b1);
    do_write(1023, 511, 1'b1);
    check("lit_oor", int'(lit_count), 0);
    model = '0;
    run_scan(0);

    // Back-pressure pattern, all zeros
    run_scan(1);

    // Stall at (3,1), write it lit, pulse start mid-scan
    model = '0; model[16] = 1'b1;
    run_scan(2);
    check("lit_after_stall", int'(lit_count), 1);

    // Async reset mid-scan at (4,2)
    push_scan();
    rd_ready = 1'b1;
    pulse_start();
    n = 0;
    while (!(rd_valid && rd_x == 10'd4 && rd_y == 9'd2) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_4_2", int'(rd_valid && rd_x == 10'd4 && rd_y == 9'd2), 1);
    dp = done_pulses;
    async_reset();
    check("no_done_after_abort", done_pulses, dp);
    check("abort_done_low", int'(done), 0);
    model = '0;
    run_scan(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
